// File: rtl/rr_index_gen_pkg.sv
// Shared constants and state encoding for the round-robin index generator.
package rr_index_gen_pkg;

  localparam int N_REQ = 64;
  localparam int IDX_W = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick64.sv
// Combinational round-robin pick: first pending bit at or after ptr, wrapping 63 -> 0.
module rr_pick64
  import rr_index_gen_pkg::*;
(
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] sel
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Rotating the doubled vector puts pending[ptr] at bit 0.
  assign dbl = {pending, pending} >> ptr;
  assign rot = dbl[N_REQ-1:0];
  assign hit = |rot;

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // IDX_W-bit add wraps naturally mod 64.
  assign sel = ptr + off;

endmodule

// File: rtl/rr_index_gen.sv
// Round-robin index generator feeding the 6-to-64 decoder; registered idx with valid/ready.
// Optional grant counter output enabled by defining RR_INDEX_GEN_STATS_EN.
//
// state    | meaning
// ST_EMPTY | no index presented, idx_valid=0
// ST_HOLD  | idx presented and held until accepted, idx_valid=1
module rr_index_gen
  import rr_index_gen_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_set,
  input  logic             flush,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [N_REQ-1:0] pending,
  output logic             busy
`ifdef RR_INDEX_GEN_STATS_EN
  ,output logic [15:0]     grant_cnt
`endif
);

  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  state_e           state_q, state_d;

  logic             hit;
  logic [IDX_W-1:0] sel;
  logic             slot_free;
  logic             take;
  logic [N_REQ-1:0] clear_mask;

  rr_pick64 u_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .hit     (hit),
    .sel     (sel)
  );

  assign slot_free  = (state_q == ST_EMPTY) || idx_ready;
  assign take       = slot_free && hit && !flush;
  assign clear_mask = take ? (N_REQ'(1) << sel) : '0;

  always_comb begin
    pending_d = (pending_q & ~clear_mask) | req_set;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    state_d   = state_q;
    if (flush) begin
      // Flush discards same-cycle requests; ptr keeps its rotation position.
      pending_d = '0;
      state_d   = ST_EMPTY;
    end else if (slot_free) begin
      if (hit) begin
        idx_d   = sel;
        ptr_d   = sel + IDX_W'(1);
        state_d = ST_HOLD;
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      state_q   <= ST_EMPTY;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = (state_q == ST_HOLD);
  assign pending   = pending_q;
  assign busy      = (|pending_q) || idx_valid;

`ifdef RR_INDEX_GEN_STATS_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;

  // Survives flush; only reset clears it.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (idx_valid && idx_ready && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) grant_cnt_q <= '0;
    else          grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_rr_index_gen.sv
// Bench for rr_index_gen: directed steps plus random traffic against a behavioural model.
module tb_rr_index_gen;

  logic        clk;
  logic        reset_n;
  logic [63:0] req_set;
  logic        flush;
  logic [5:0]  idx;
  logic        idx_valid;
  logic        idx_ready;
  logic [63:0] pending;
  logic        busy;
  logic [15:0] grant_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pending;
  int          m_ptr;
  bit          m_valid;
  int          m_idx;
  int          m_cnt;

  rr_index_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_set   (req_set),
    .flush     (flush),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .pending   (pending),
    .busy      (busy)
`ifdef RR_INDEX_GEN_STATS_EN
    ,.grant_cnt(grant_cnt)
`endif
  );

`ifndef RR_INDEX_GEN_STATS_EN
  assign grant_cnt = 16'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_ptr     = 0;
    m_valid   = 0;
    m_idx     = 0;
    m_cnt     = 0;
  endtask

  // Serve the first pending request in circular order starting at ptr.
  task automatic model_step(input logic [63:0] req, input logic fl, input logic rdy);
    logic [63:0] nxt;
    bit          found;
    int          b;
    if (m_valid && rdy && m_cnt < 65535) m_cnt++;
    if (fl) begin
      m_pending = '0;
      m_valid   = 0;
    end else begin
      nxt = m_pending;
      if (!m_valid || rdy) begin
        found = 0;
        for (int j = 0; j < 64 && !found; j++) begin
          b = (m_ptr + j) % 64;
          if (m_pending[b]) begin
            found   = 1;
            m_idx   = b;
            m_ptr   = (b + 1) % 64;
            nxt[b]  = 1'b0;
          end
        end
        m_valid = found;
      end
      m_pending = nxt | req;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_valid"}, 64'(idx_valid), 64'(m_valid));
    if (m_valid) chk({tag, "_idx"}, 64'(idx), 64'(m_idx));
    chk({tag, "_pend"}, pending, m_pending);
    chk({tag, "_busy"}, 64'(busy), 64'((m_pending != 0) || m_valid));
`ifdef RR_INDEX_GEN_STATS_EN
    chk({tag, "_gcnt"}, 64'(grant_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic cycle(input logic [63:0] req, input logic fl, input logic rdy);
    req_set   = req;
    flush     = fl;
    idx_ready = rdy;
    @(posedge clk);
    model_step(req, fl, rdy);
    #1;
    compare_all("cyc");
  endtask

  initial begin
    logic [63:0] r;
    reset_n   = 1'b0;
    req_set   = '0;
    flush     = 1'b0;
    idx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    chk("rst_valid", 64'(idx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pend", pending, 64'd0);
    repeat (5) cycle('0, 1'b0, 1'b0);
    chk("idle_valid", 64'(idx_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Pulse three requests, served 0, 4, 63 one per cycle
    cycle(64'h8000_0000_0000_0011, 1'b0, 1'b1);
    chk("lat_valid", 64'(idx_valid), 64'd0);
    cycle('0, 1'b0, 1'b1);
    chk("seq0", 64'(idx), 64'd0);
    cycle('0, 1'b0, 1'b1);
    chk("seq4", 64'(idx), 64'd4);
    cycle('0, 1'b0, 1'b1);
    chk("seq63", 64'(idx), 64'd63);
    cycle('0, 1'b0, 1'b1);
    chk("seq_end", 64'(idx_valid), 64'd0);

    // Move ptr to 5, then wrap-around order 9 then 2
    cycle(64'h10, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    chk("ptr5_idx", 64'(idx), 64'd4);
    cycle('0, 1'b0, 1'b1);
    cycle(64'h204, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    chk("wrap9", 64'(idx), 64'd9);
    cycle('0, 1'b0, 1'b1);
    chk("wrap2", 64'(idx), 64'd2);
    cycle('0, 1'b0, 1'b1);

    // Back-pressure holds idx stable
    cycle(64'h180, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    chk("hold_idx0", 64'(idx), 64'd7);
    repeat (4) cycle('0, 1'b0, 1'b0);
    chk("hold_idx", 64'(idx), 64'd7);
    chk("hold_pend", pending, 64'h100);
    cycle('0, 1'b0, 1'b1);
    chk("hold_next", 64'(idx), 64'd8);
    cycle('0, 1'b0, 1'b1);

    // Same-cycle set of the bit being served: set wins
    cycle(64'h8, 1'b0, 1'b1);
    cycle(64'h8, 1'b0, 1'b1);
    chk("setwin_idx", 64'(idx), 64'd3);
    chk("setwin_pend", pending, 64'h8);
    cycle('0, 1'b0, 1'b1);
    chk("setwin_again", 64'(idx), 64'd3);
    chk("setwin_valid", 64'(idx_valid), 64'd1);

    // Flush discards same-cycle requests
    cycle(64'h30, 1'b0, 1'b0);
    cycle(64'hFF, 1'b1, 1'b0);
    chk("flush_pend", pending, 64'd0);
    chk("flush_valid", 64'(idx_valid), 64'd0);
    cycle('0, 1'b0, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = '0;
      if ($urandom_range(0, 2) == 0) r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      cycle(r, ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0));
    end

    // Async reset in HOLD, between edges
    cycle(64'h0010_0000, 1'b0, 1'b0);
    cycle(64'h0400_0000, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(idx_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(idx_valid), 64'd0);
    chk("arst_pend", pending, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
`ifdef RR_INDEX_GEN_STATS_EN
    chk("arst_gcnt", 64'(grant_cnt), 64'd0);
`endif
    req_set   = '0;
    idx_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Three accepted handshakes after reset
    cycle(64'hE, 1'b0, 1'b1);
    repeat (4) cycle('0, 1'b0, 1'b1);
    chk("post_idle", 64'(idx_valid), 64'd0);
`ifdef RR_INDEX_GEN_STATS_EN
    chk("gcnt3", 64'(grant_cnt), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
